// File: rtl/sta_tile_sequencer.sv
// sta_tile_sequencer: tile-level controller for the systolic tensor array.
// Accepts K beats per tile, skews data columns / weight rows by PE_LATENCY
// per hop, clears the accumulators at tile start, waits out the array drain
// and presents the captured array result on a valid/ready stream.
// Optional macro STA_SEQ_DOUBLE_BUF_EN: the result lives in a holding
// register so the FSM returns to IDLE right after capture and the next tile
// can start while the previous result is still waiting for its handshake.
module sta_tile_sequencer #(
    parameter int N               = 2,
    parameter int M               = 2,
    parameter int B               = 4,
    parameter int QUANTIZED_WIDTH = 8,
    parameter int PE_LATENCY      = 4,
    parameter int K_MAX           = 16,
    parameter int PE_RESULT_WIDTH = 16*QUANTIZED_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic [$clog2(K_MAX+1)-1:0]          k_len_i,
    output logic                                busy_o,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [N*2*B*QUANTIZED_WIDTH-1:0]    in_data_i,
    input  logic [M*2*B*QUANTIZED_WIDTH-1:0]    in_weights_i,
    output logic [N*2*B*QUANTIZED_WIDTH-1:0]    sta_data_o,
    output logic [M*2*B*QUANTIZED_WIDTH-1:0]    sta_weights_o,
    output logic                                sta_clear_o,
    input  logic [M*N*PE_RESULT_WIDTH-1:0]      sta_result_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [M*N*PE_RESULT_WIDTH-1:0]      res_data_o,
    output logic [15:0]                         tile_count_o
);

    localparam int LW           = 2*B*QUANTIZED_WIDTH;
    localparam int KW           = $clog2(K_MAX+1);
    localparam int RW           = M*N*PE_RESULT_WIDTH;
    localparam int DRAIN_CYCLES = (M+N)*PE_LATENCY + 1;
    localparam int DW           = $clog2(DRAIN_CYCLES+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [KW-1:0]   r_kLen;
    logic [KW-1:0]   r_beatCnt;
    logic [DW-1:0]   r_drainCnt;
    logic            r_resValid;
    logic [RW-1:0]   r_resData;
    logic [15:0]     r_tileCount;

    logic            w_startOk;
    logic            w_xfer;
    logic            w_drainLast;
    logic            w_capture;
    logic            w_resHandshake;
    logic [N*LW-1:0] w_beatData;
    logic [M*LW-1:0] w_beatWeights;

    assign w_startOk      = start_i && (k_len_i != '0) && (k_len_i <= KW'(K_MAX));
    assign w_xfer         = in_valid_i && in_ready_o;
    assign w_drainLast    = (r_drainCnt == DW'(DRAIN_CYCLES - 1));
    assign w_resHandshake = r_resValid && res_ready_i;

    // Bubbles and non-FEED cycles push zeros so they add nothing to the accumulators.
    assign w_beatData    = w_xfer ? in_data_i    : '0;
    assign w_beatWeights = w_xfer ? in_weights_i : '0;

    assign busy_o       = (r_state != S_IDLE);
    assign res_valid_o  = r_resValid;
    assign res_data_o   = r_resData;
    assign tile_count_o = r_tileCount;

    // Next-state decode plus the combinational handshake/clear/capture strobes.
    always_comb begin
        w_nextState = r_state;
        in_ready_o  = 1'b0;
        sta_clear_o = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_startOk) begin
                    sta_clear_o = 1'b1;
                    w_nextState = S_FEED;
                end
            end
            S_FEED: begin
                in_ready_o = 1'b1;
                if (in_valid_i && (r_beatCnt == r_kLen - KW'(1))) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drainLast) begin
`ifdef STA_SEQ_DOUBLE_BUF_EN
                    if (!r_resValid || res_ready_i) begin
                        w_capture   = 1'b1;
                        w_nextState = S_IDLE;
                    end
`else
                    w_capture   = 1'b1;
                    w_nextState = S_HOLD;
`endif
                end
            end
            S_HOLD: begin
`ifdef STA_SEQ_DOUBLE_BUF_EN
                w_nextState = S_IDLE;
`else
                if (res_ready_i) begin
                    w_nextState = S_IDLE;
                end
`endif
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register, tile counters and the result capture/holding register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_kLen      <= '0;
            r_beatCnt   <= '0;
            r_drainCnt  <= '0;
            r_resValid  <= 1'b0;
            r_resData   <= '0;
            r_tileCount <= '0;
        end else begin
            r_state <= w_nextState;
            if ((r_state == S_IDLE) && w_startOk) begin
                r_kLen    <= k_len_i;
                r_beatCnt <= '0;
            end else if (w_xfer) begin
                r_beatCnt <= r_beatCnt + KW'(1);
            end
            if (r_state != S_DRAIN) begin
                r_drainCnt <= '0;
            end else if (!w_drainLast) begin
                r_drainCnt <= r_drainCnt + DW'(1);
            end
            if (w_capture) begin
                r_resData <= sta_result_i;
            end
            if (w_capture) begin
                r_resValid <= 1'b1;
            end else if (w_resHandshake) begin
                r_resValid <= 1'b0;
            end
            if (w_resHandshake) begin
                r_tileCount <= r_tileCount + 16'd1;
            end
        end
    end

    assign sta_data_o[LW-1:0]    = w_beatData[LW-1:0];
    assign sta_weights_o[LW-1:0] = w_beatWeights[LW-1:0];

    for (genvar n = 1; n < N; n++) begin : g_dataSkew
        logic [LW-1:0] r_pipe [n*PE_LATENCY];
        // Delay data column n by n*PE_LATENCY cycles.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                for (int i = 0; i < n*PE_LATENCY; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_beatData[n*LW +: LW];
                for (int i = 1; i < n*PE_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end
        assign sta_data_o[n*LW +: LW] = r_pipe[n*PE_LATENCY-1];
    end

    for (genvar m = 1; m < M; m++) begin : g_weightSkew
        logic [LW-1:0] r_pipe [m*PE_LATENCY];
        // Delay weight row m by m*PE_LATENCY cycles.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                for (int i = 0; i < m*PE_LATENCY; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= w_beatWeights[m*LW +: LW];
                for (int i = 1; i < m*PE_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end
        assign sta_weights_o[m*LW +: LW] = r_pipe[m*PE_LATENCY-1];
    end

endmodule

// File: tb/tb_sta_tile_sequencer.sv
// tb_sta_tile_sequencer: randomized bench for sta_tile_sequencer with a
// timestamp-based reference model and a result scoreboard queue.
module tb_sta_tile_sequencer;

    localparam int N            = 2;
    localparam int M            = 2;
    localparam int B            = 4;
    localparam int QW           = 8;
    localparam int PL           = 4;
    localparam int K_MAX        = 16;
    localparam int PRW          = 16*QW;
    localparam int LW           = 2*B*QW;
    localparam int KW           = $clog2(K_MAX+1);
    localparam int DL           = N*LW;
    localparam int WL           = M*LW;
    localparam int RW           = M*N*PRW;
    localparam int DRAIN_CYCLES = (M+N)*PL + 1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [KW-1:0] k_len_i;
    logic          busy_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [DL-1:0] in_data_i;
    logic [WL-1:0] in_weights_i;
    logic [DL-1:0] sta_data_o;
    logic [WL-1:0] sta_weights_o;
    logic          sta_clear_o;
    logic [RW-1:0] sta_result_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [RW-1:0] res_data_o;
    logic [15:0]   tile_count_o;

    sta_tile_sequencer dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .k_len_i      (k_len_i),
        .busy_o       (busy_o),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .in_weights_i (in_weights_i),
        .sta_data_o   (sta_data_o),
        .sta_weights_o(sta_weights_o),
        .sta_clear_o  (sta_clear_o),
        .sta_result_i (sta_result_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .tile_count_o (tile_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [RW-1:0] data;
        int            riseCyc;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state, valid for the cycle being evaluated.
    bit            mFeed     = 1'b0;
    int            mBeatsLeft = 0;
    int            mDoneCyc  = -1;
    bit            mHold     = 1'b0;
    int            mTiles    = 0;
    logic [RW-1:0] mTileRes  = '0;
    bit [DL-1:0]   histD [64];
    bit [WL-1:0]   histW [64];

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] randResult();
        logic [RW-1:0] r;
        for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Per-cycle model: expected busy/ready/clear, skewed lanes, result valid and tile count.
    always @(negedge clk_i) begin : modelProc
        bit          expBusy;
        bit          expClear;
        bit          xfer;
        int          kv;
        logic [DL-1:0] expD;
        logic [WL-1:0] expW;
        exp_t        e;
        if (mDoneCyc >= 0 && cyc == mDoneCyc + DRAIN_CYCLES + 1) begin
            mHold    = 1'b1;
            mDoneCyc = -1;
        end
        kv       = int'(k_len_i);
        expBusy  = mFeed || (mDoneCyc >= 0) || mHold;
        expClear = !expBusy && start_i && (kv >= 1) && (kv <= K_MAX);
        xfer     = mFeed && in_valid_i;
        histD[cyc % 64] = xfer ? in_data_i    : '0;
        histW[cyc % 64] = xfer ? in_weights_i : '0;
        for (int n = 0; n < N; n++) expD[n*LW +: LW] = histD[(cyc + 64 - n*PL) % 64][n*LW +: LW];
        for (int m = 0; m < M; m++) expW[m*LW +: LW] = histW[(cyc + 64 - m*PL) % 64][m*LW +: LW];
        checkOutput("busy", busy_o, expBusy);
        checkOutput("in_ready", in_ready_o, mFeed);
        checkOutput("sta_clear", sta_clear_o, expClear);
        checkOutput("sta_data", sta_data_o, expD);
        checkOutput("sta_weights", sta_weights_o, expW);
        checkOutput("res_valid", res_valid_o, mHold);
        checkOutput("tile_count", tile_count_o, mTiles[15:0]);
        if (reset_i) begin
            mFeed    = 1'b0;
            mDoneCyc = -1;
            mHold    = 1'b0;
            mTiles   = 0;
            for (int i = 0; i < 64; i++) begin
                histD[i] = '0;
                histW[i] = '0;
            end
            expQ.delete();
        end else begin
            if (expClear) begin
                mFeed      = 1'b1;
                mBeatsLeft = kv;
                mTileRes   = sta_result_i;
            end
            if (xfer) begin
                mBeatsLeft--;
                if (mBeatsLeft == 0) begin
                    mFeed     = 1'b0;
                    mDoneCyc  = cyc;
                    e.data    = mTileRes;
                    e.riseCyc = cyc + DRAIN_CYCLES + 1;
                    expQ.push_back(e);
                end
            end
            if (mHold && res_ready_i) begin
                mHold = 1'b0;
                mTiles++;
            end
        end
    end

    // Result monitor: pops the scoreboard when a result is presented and checks it until accepted.
    always @(negedge clk_i) begin : monitorProc
        static bit   haveCur = 1'b0;
        static exp_t cur;
        if (reset_i) begin
            haveCur = 1'b0;
        end else if (res_valid_o) begin
            if (!haveCur) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", res_valid_o, 1'b0);
                end else begin
                    cur     = expQ.pop_front();
                    haveCur = 1'b1;
                    checkOutput("res_rise_cycle", cyc, cur.riseCyc);
                end
            end
            if (haveCur) checkOutput("res_data", res_data_o, cur.data);
            if (res_ready_i) haveCur = 1'b0;
        end
    end

    // Drive one tile: start, k beats with the chosen valid pattern, then hold and accept the result.
    task automatic applyStimulus(input int k, input logic [31:0] validPat, input bit randValid,
                                 input bit fixedData, input int holdCycles, input int abortAfter);
        int beats = 0;
        int idx   = 0;
        int cnt   = 0;
        bit v;
        @(posedge clk_i); #1;
        sta_result_i = fixedData ? {32{16'h1234}} : randResult();
        start_i      = 1'b1;
        k_len_i      = KW'(k);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (beats < k && idx < 200) begin
            v            = randValid ? ($urandom_range(0, 2) != 0) : validPat[idx % 32];
            in_valid_i   = v;
            in_data_i    = fixedData ? {16{8'd5}} : rand128();
            in_weights_i = fixedData ? {16{8'd2}} : rand128();
            @(posedge clk_i); #1;
            if (v) beats++;
            idx++;
            if (abortAfter > 0 && beats == abortAfter) begin
                in_valid_i   = 1'b0;
                in_data_i    = '0;
                in_weights_i = '0;
                reset_i      = 1'b1;
                repeat (2) @(posedge clk_i);
                #1;
                reset_i = 1'b0;
                repeat (25) @(posedge clk_i);
                #1;
                return;
            end
        end
        in_valid_i   = 1'b0;
        in_data_i    = '0;
        in_weights_i = '0;
        while (!res_valid_o && cnt < 40) begin
            @(posedge clk_i); #1;
            cnt++;
        end
        if (!res_valid_o) checkOutput("res_valid_timeout", res_valid_o, 1'b1);
        for (int i = 0; i < holdCycles; i++) begin
            start_i = 1'($urandom_range(0, 1));
            k_len_i = KW'(3);
            @(posedge clk_i); #1;
        end
        start_i     = 1'b0;
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
    endtask

    initial begin
        reset_i      = 1'b1;
        start_i      = 1'b0;
        k_len_i      = '0;
        in_valid_i   = 1'b0;
        in_data_i    = '0;
        in_weights_i = '0;
        sta_result_i = '0;
        res_ready_i  = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        $display("[TB] single-beat tile with constant lanes");
        applyStimulus(1, 32'hFFFF_FFFF, 1'b0, 1'b1, 2, 0);
        $display("[TB] three beats with bubbles");
        applyStimulus(3, 32'b10101, 1'b0, 1'b0, 1, 0);
        $display("[TB] long hold with ignored starts");
        applyStimulus(2, 32'hFFFF_FFFF, 1'b0, 1'b0, 10, 0);
        $display("[TB] reset in the middle of a tile");
        applyStimulus(4, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 2);

        $display("[TB] out-of-range tile lengths");
        @(posedge clk_i); #1;
        start_i = 1'b1;
        k_len_i = KW'(0);
        @(posedge clk_i); #1;
        k_len_i = KW'(17);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;

        $display("[TB] random tiles");
        for (int t = 0; t < 20; t++) begin
            applyStimulus($urandom_range(1, K_MAX), 32'h0, 1'b1, 1'b0, $urandom_range(0, 4), 0);
        end
        applyStimulus(K_MAX, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0);

        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("pending_results", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sta_tile_sequencer.md
Name: sta_tile_sequencer

Overview:
Tile-level front/back-end controller for the systolic tensor array (STA).
- Accepts K input beats per tile on a valid/ready stream.
- Applies the diagonal skew the array requires: column n data delayed n*PE_LATENCY cycles, row m weights delayed m*PE_LATENCY cycles.
- Clears the array accumulators at tile start and waits out the array drain latency.
- Captures `result_o` of the array and presents it on a valid/ready result stream.
- Sits directly between the DMA/buffer layer and the STA instance.

Parameters:
- N, 2: PE columns of the driven STA.
- M, 2: PE rows of the driven STA.
- B, 4: multipliers per dot-product unit; each lane vector is 2*B elements.
- QUANTIZED_WIDTH, 8: bits per data/weight element, signed.
- PE_LATENCY, 4: cycles per PE hop.
- K_MAX, 16: maximum beats per tile.
- PE_RESULT_WIDTH, 16*QUANTIZED_WIDTH: concatenated per-PE result width (4 DPs x 4*QUANTIZED_WIDTH).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  reset; synchronous, active-high.
- start_i  in  1  begin a tile; sampled only in IDLE.
- k_len_i  in  $clog2(K_MAX+1)  beats in this tile; latched on accepted start.
- busy_o  out  1  high in any state other than IDLE.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat ready.
- in_data_i  in  N*2*B*QUANTIZED_WIDTH  packed data, column n at slice n.
- in_weights_i  in  M*2*B*QUANTIZED_WIDTH  packed weights, row m at slice m.
- sta_data_o  out  N*2*B*QUANTIZED_WIDTH  skewed data to STA `data_i`.
- sta_weights_o  out  M*2*B*QUANTIZED_WIDTH  skewed weights to STA `weights_i`.
- sta_clear_o  out  1  one-cycle accumulator clear to STA.
- sta_result_i  in  M*N*PE_RESULT_WIDTH  STA `result_o`, packed [m][n].
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.
- res_data_o  out  M*N*PE_RESULT_WIDTH  captured tile result.
- tile_count_o  out  16  completed tiles; wraps 0xFFFF->0.

Behaviour:
- Reset values: every output 0, FSM in IDLE, skew lines zeroed, counters zeroed.
  - Reset asserted in any state (including mid-FEED/DRAIN) aborts the tile; no partial result is emitted.
- FSM states: IDLE, FEED, DRAIN, HOLD.
- IDLE
  - If start_i=1 and 1<=k_len_i<=K_MAX: latch k_len, pulse sta_clear_o for that cycle, go to FEED.
  - start_i with k_len_i=0 or k_len_i>K_MAX is ignored; FSM stays IDLE.
- FEED
  - in_ready_o=1.
  - A beat transfers when in_valid_i && in_ready_o.
  - Beat counter increments per transfer; the cycle the k_len-th beat transfers, FSM goes to DRAIN and in_ready_o is 0 from the next cycle.
  - Cycles without a transfer (bubbles) inject all-zero vectors into the skew lines; zeros contribute nothing to accumulation.
- Skew
  - Slice n of sta_data_o equals the slice n value presented n*PE_LATENCY cycles earlier.
  - Slice m of sta_weights_o equals the slice m value presented m*PE_LATENCY cycles earlier.
  - Slice 0 of each is combinational from the accepted beat or zero.
  - Outside FEED, zeros are pushed.
- DRAIN
  - Counts DRAIN_CYCLES = (M+N)*PE_LATENCY + 1 cycles.
  - On the final count: register sta_result_i into res_data_o, set res_valid_o, go to HOLD.
- HOLD
  - res_valid_o and res_data_o stay stable until res_ready_i=1.
  - On handshake: res_valid_o drops next cycle, tile_count_o increments, FSM returns to IDLE.
  - start_i is ignored.
- Latency: res_valid_o rises exactly DRAIN_CYCLES+1 cycles after the cycle the last beat transferred.
- start_i while busy_o=1 is always ignored.
- Arithmetic: none on data. Results are passed through bit-exact, no sign extension or truncation.

Optional Feature:
Macro: STA_SEQ_DOUBLE_BUF_EN.
- Defined:
  - Captured result goes to a holding register and the FSM returns to IDLE the cycle after capture. The next tile may start while res_valid_o is still pending.
  - If a second capture would occur while the holding register is still valid, DRAIN stalls on its final count until the handshake frees the register.
  - tile_count_o increments on the result handshake.
- Not defined: single buffer; FSM waits in HOLD as described above.

Test Plan:
- Reset held 3 cycles -> all outputs 0, in_ready_o=0, busy_o=0, tile_count_o=0.
- k_len_i=1, data all 5, weights all 2, N=M=2, PE_LATENCY=4 -> sta_clear_o high exactly one cycle (start cycle); column-1 data (5s) on sta_data_o exactly 4 cycles after column 0. Model drives sta_result_i=0x1234 per word -> res_valid_o rises 18 cycles after the beat, res_data_o=0x1234 words, tile_count_o=1 after handshake.
- k_len_i=3 with in_valid_i pattern 1,0,1,0,1 -> exactly 3 transfers; zero vector injected on bubble cycles; in_ready_o=0 the cycle after the 3rd transfer.
- res_ready_i held 0 for 10 cycles in HOLD -> res_valid_o and res_data_o stable, start_i pulses ignored, busy_o=1. Then ready=1 -> returns to IDLE next cycle.
- reset_i asserted mid-FEED after 2 of 4 beats -> next cycle all outputs 0, skew lines zero, no res_valid_o ever for that tile.
- start_i with k_len_i=0 and with k_len_i=17 -> busy_o stays 0, sta_clear_o stays 0.
